// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoding byte RAM downstream of the SPI slave FSM.
// Define ADDR_AUTOINC_EN for auto-incrementing read/write addresses (streaming).
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int TX_HOLD   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       cmd_err
);
   localparam int CW = $clog2(TX_HOLD);
   typedef enum logic {T_IDLE, T_HOLD} state_t;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 rd_vld_q, rd_vld_d, cmd_err_q, cmd_err_d, rx_valid_q;
   logic [7:0]           mem [MEM_DEPTH];
   logic [1:0]           op;
   logic                 accept, mem_we, rd_ok;

   // rx_valid is a level held for several cycles; act only on its rising edge
   assign op       = rx_data[9:8];
   assign accept   = rx_valid & ~rx_valid_q;
   assign mem_we   = accept && op == 2'b01;
   assign rd_ok    = accept && op == 2'b11 && rd_vld_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = state_q == T_HOLD;
   assign cmd_err  = cmd_err_q;

   always_comb begin
      wr_addr_d = (accept && op == 2'b00) ? rx_data[ADDR_SIZE-1:0] : wr_addr_q;
      rd_addr_d = (accept && op == 2'b10) ? rx_data[ADDR_SIZE-1:0] : rd_addr_q;
      rd_vld_d  = (accept && op == 2'b10) ? 1'b1 : rd_ok ? 1'b0 : rd_vld_q;
`ifdef ADDR_AUTOINC_EN
      if (mem_we) wr_addr_d = wr_addr_q + 1'b1;
      if (rd_ok) begin
         rd_addr_d = rd_addr_q + 1'b1;
         rd_vld_d  = 1'b1;
      end
`endif
      tx_data_d = rd_ok ? mem[rd_addr_q] : tx_data_q;
      cmd_err_d = accept && op == 2'b11 && !rd_vld_q;
      state_d   = rd_ok ? T_HOLD : (state_q == T_HOLD && cnt_q == '0) ? T_IDLE : state_q;
      cnt_d     = rd_ok ? CW'(TX_HOLD - 1) : (state_q == T_HOLD && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= T_IDLE;
         cnt_q      <= '0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         rd_vld_q   <= 1'b0;
         tx_data_q  <= '0;
         cmd_err_q  <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         rd_vld_q   <= rd_vld_d;
         tx_data_q  <= tx_data_d;
         cmd_err_q  <= cmd_err_d;
         rx_valid_q <= rx_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && mem_we) mem[wr_addr_q] <= rx_data[7:0];
   end
endmodule
